// File: rtl/cpu_uart.sv
// CPU-mapped 8N1 UART: data/status registers, TX and RX state machines, RX buffer.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX holds a single byte.
module cpu_uart #(
  parameter int BAUD_DIV = 35
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       rx,
  output logic       tx
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic rd_data, rd_stat, wr_data, wr_ctrl;
  logic rxie, txie, txrdy, rxrdy, overrun, framing;
  logic [7:0] status;

  tx_state_t tx_state, tx_state_next;
  logic [CW-1:0] tx_baud, tx_baud_next;
  logic [2:0] tx_bit, tx_bit_next;
  logic [7:0] tx_shift, tx_shift_next, tx_hold;
  logic tx_load, tx_line_next;

  rx_state_t rx_state, rx_state_next;
  logic [CW-1:0] rx_baud, rx_baud_next;
  logic [2:0] rx_bit, rx_bit_next;
  logic [7:0] rx_shift, rx_shift_next, rx_head;
  logic rx_p0, rx_p1, rx_p2;
  logic rx_done, pop, push, ovr_evt, frm_evt;

  assign rd_data = cs & ~we & ~rs;
  assign rd_stat = cs & ~we & rs;
  assign wr_data = cs & we & ~rs;
  assign wr_ctrl = cs & we & rs;

  assign status = {irq, 3'b000, framing, overrun, txrdy, rxrdy};

  // ---- CPU register interface ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= 8'h00;
      irq     <= 1'b0;
      rxie    <= 1'b0;
      txie    <= 1'b0;
      txrdy   <= 1'b1;
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      if (rd_stat)      dout <= status;
      else if (rd_data) dout <= rx_head;
      irq <= (rxie & rxrdy) | (txie & txrdy);
      if (wr_ctrl) begin
        rxie <= din[0];
        txie <= din[1];
      end
      if (tx_load)                txrdy <= 1'b1;
      else if (wr_data && txrdy)  txrdy <= 1'b0;
      // Clear-on-read takes the pre-read value into dout; a same-cycle event wins.
      overrun <= (overrun & ~rd_stat) | ovr_evt;
      framing <= (framing & ~rd_stat) | frm_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_data && txrdy) tx_hold <= din;
  end

  // ---- TX state machine ----
  always_comb begin
    tx_state_next = tx_state;
    tx_baud_next  = tx_baud + CW'(1);
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    tx_load       = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_baud_next = '0;
        if (!txrdy) begin
          tx_load       = 1'b1;
          tx_shift_next = tx_hold;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_next  = '0;
          tx_bit_next   = 3'd0;
          tx_state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_next  = '0;
          tx_shift_next = {1'b0, tx_shift[7:1]};
          tx_bit_next   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_next = '0;
          // A waiting byte starts immediately so back-to-back frames have no gap.
          if (!txrdy) begin
            tx_load       = 1'b1;
            tx_shift_next = tx_hold;
            tx_state_next = TX_START;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
    tx_line_next = (tx_state_next == TX_START) ? 1'b0 :
                   (tx_state_next == TX_DATA)  ? tx_shift_next[0] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= 3'd0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_baud  <= tx_baud_next;
      tx_bit   <= tx_bit_next;
      tx       <= tx_line_next;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_next;
  end

  // ---- RX synchroniser: rx_p0/rx_p1 resolve metastability, rx_p2 is the edge-detect history ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // ---- RX state machine ----
  always_comb begin
    rx_state_next = rx_state;
    rx_baud_next  = rx_baud + CW'(1);
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_done       = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_baud_next = '0;
        if (rx_p2 && !rx_p1) rx_state_next = RX_START;
      end
      RX_START: begin
        if (rx_baud == BAUD_HALF) begin
          rx_baud_next  = '0;
          rx_bit_next   = 3'd0;
          rx_state_next = rx_p1 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_next  = '0;
          rx_shift_next = {rx_p1, rx_shift[7:1]};
          rx_bit_next   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_next  = '0;
          rx_done       = 1'b1;
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  assign frm_evt = rx_done & ~rx_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= 3'd0;
    end else begin
      rx_state <= rx_state_next;
      rx_baud  <= rx_baud_next;
      rx_bit   <= rx_bit_next;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_next;
  end

  // ---- RX buffer: an arriving byte takes priority over a same-cycle pop ----
`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo [4];
  logic [1:0] wptr, rptr;
  logic [2:0] count;

  assign rxrdy   = (count != 3'd0);
  assign pop     = rd_data & rxrdy;
  assign push    = rx_done & ((count != 3'd4) | pop);
  assign ovr_evt = rx_done & (count == 3'd4) & ~pop;
  assign rx_head = fifo[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= rx_shift;
  end
`else
  logic [7:0] rx_buf;
  logic       rx_full;

  assign rxrdy   = rx_full;
  assign pop     = rd_data & rx_full;
  assign push    = rx_done & (~rx_full | pop);
  assign ovr_evt = rx_done & rx_full & ~pop;
  assign rx_head = rx_buf;

  always_ff @(posedge clk) begin
    if (reset)     rx_full <= 1'b0;
    else if (push) rx_full <= 1'b1;
    else if (pop)  rx_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) rx_buf <= rx_shift;
  end
`endif

endmodule
